// File: rtl/bht_ctrl.sv
// ---------------------------------------------------------------------------
// bht_ctrl
// Controller for a branch history table of 2^IDX_W two-bit saturating
// counters held in an external single-port RAM. Lookups read the counter
// for the fetch PC. Resolved branches are queued and applied later as
// read-modify-write sequences on the same port.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   lookup_valid, lookup_PC   fetch prediction request
//   lookup_ready              request granted this cycle (with lookup_valid)
//   predict_valid/_taken      prediction, one cycle after a granted lookup
//   upd_valid, upd_PC,        resolved branch, pushed into the update queue
//   upd_taken, upd_ready        on upd_valid && upd_ready
//   init_req                  one-cycle pulse: flush and re-initialise table
//   busy                      init sweep, queued updates or RMW outstanding
//   tbl_en, tbl_we, tbl_addr, single-port table interface; tbl_rdata is
//   tbl_wdata, tbl_rdata        valid the cycle after a read
// ---------------------------------------------------------------------------
module bht_ctrl #(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_PC,
    output logic             lookup_ready,
    output logic             predict_valid,
    output logic             predict_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_PC,
    input  logic             upd_taken,
    output logic             upd_ready,
    input  logic             init_req,
    output logic             busy,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata
);

    localparam int QAW = $clog2(QDEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [QAW:0]     PTR_ONE  = {{QAW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    // Two-bit saturating counter step towards the resolved direction.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] sweep_r;
    logic [IDX_W:0]   q_mem_r [QDEPTH];
    logic [QAW:0]     wr_ptr_r;
    logic [QAW:0]     rd_ptr_r;
    logic [3:0]       starve_r;
    logic [1:0]       cnt_r;
    logic             predict_valid_r;

    logic             q_empty_s;
    logic             q_full_s;
    logic             push_s;
    logic             pop_s;
    logic             upd_pend_s;
    logic             force_s;
    logic             lookup_grant_s;
    logic             upd_grant_s;
    logic             en_s;
    logic             we_s;
    logic [IDX_W-1:0] addr_s;
    logic [1:0]       wdata_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_taken_s;
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic             unused_pc_bits_s;

    assign lookup_idx_s = lookup_PC[IDX_W+1:2];
    assign upd_idx_s    = upd_PC[IDX_W+1:2];
    assign unused_pc_bits_s = ^{lookup_PC[31:IDX_W+2], lookup_PC[1:0],
                                upd_PC[31:IDX_W+2], upd_PC[1:0]};

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign q_empty_s = (wr_ptr_r == rd_ptr_r);
    assign q_full_s  = (wr_ptr_r[QAW] != rd_ptr_r[QAW]) &&
                       (wr_ptr_r[QAW-1:0] == rd_ptr_r[QAW-1:0]);
    assign {head_idx_s, head_taken_s} = q_mem_r[rd_ptr_r[QAW-1:0]];

    assign upd_pend_s   = ((state_r == IDLE) && !q_empty_s) || (state_r == WR);
    assign upd_ready    = !q_full_s && (state_r != INIT);
    assign push_s       = upd_valid && upd_ready && !init_req;
    assign pop_s        = upd_grant_s && (state_r == WR);
    assign lookup_ready = (state_r != INIT) && !force_s;
    assign busy         = (state_r != IDLE) || !q_empty_s;

    // Table strobes are held off while reset is asserted even though the
    // FSM already sits in INIT.
    assign tbl_en        = en_s && rst;
    assign tbl_we        = we_s && rst;
    assign tbl_addr      = addr_s;
    assign tbl_wdata     = wdata_s;
    assign predict_valid = predict_valid_r;
    assign predict_taken = predict_valid_r && tbl_rdata[1];

    // Port arbitration, table strobes and next-state selection.
    always_comb begin
        state_nxt_s    = state_r;
        force_s        = 1'b0;
        lookup_grant_s = 1'b0;
        upd_grant_s    = 1'b0;
        en_s           = 1'b0;
        we_s           = 1'b0;
        addr_s         = {IDX_W{1'b0}};
        wdata_s        = 2'b00;
        if (state_r == INIT) begin
            en_s    = 1'b1;
            we_s    = 1'b1;
            addr_s  = sweep_r;
            wdata_s = 2'b01;
            if (sweep_r == LAST_IDX) begin
                state_nxt_s = IDLE;
            end else begin
                state_nxt_s = INIT;
            end
        end else begin
            // A starved update op takes the port from a waiting lookup.
            force_s        = upd_pend_s && (starve_r == 4'd8);
            lookup_grant_s = lookup_valid && !force_s;
            // init_req aborts the RMW, so no update access goes out with it.
            upd_grant_s    = upd_pend_s && !lookup_grant_s && !init_req;
            if (lookup_grant_s) begin
                en_s   = 1'b1;
                we_s   = 1'b0;
                addr_s = lookup_idx_s;
            end else if (upd_grant_s) begin
                en_s    = 1'b1;
                we_s    = (state_r == WR);
                addr_s  = head_idx_s;
                wdata_s = cnt_r;
            end else begin
                en_s = 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (upd_grant_s) begin
                        state_nxt_s = CAP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CAP: state_nxt_s = WR;
                WR: begin
                    if (upd_grant_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WR;
                    end
                end
                default: state_nxt_s = INIT;
            endcase
        end
    end

    // FSM state register; init_req restarts the sweep from any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= INIT;
        end else if (init_req) begin
            state_r <= INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Init sweep address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_r <= {IDX_W{1'b0}};
        end else if (init_req || (state_r != INIT)) begin
            sweep_r <= {IDX_W{1'b0}};
        end else begin
            sweep_r <= sweep_r + IDX_ONE;
        end
    end

    // Update queue pointers; init_req flushes and drops any same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(QAW+1){1'b0}};
            rd_ptr_r <= {(QAW+1){1'b0}};
        end else if (init_req) begin
            wr_ptr_r <= {(QAW+1){1'b0}};
            rd_ptr_r <= {(QAW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Update queue storage: {table index, resolved direction}.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_mem_r[wr_ptr_r[QAW-1:0]] <= {upd_idx_s, upd_taken};
        end
    end

    // Starvation counter for a pending update op denied by lookups.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_r <= 4'd0;
        end else if (init_req || upd_grant_s) begin
            starve_r <= 4'd0;
        end else if (upd_pend_s && (state_r != INIT) && (starve_r != 4'hF)) begin
            starve_r <= starve_r + 4'd1;
        end
    end

    // New counter value captured from the read data while in CAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 2'b00;
        end else if (state_r == CAP) begin
            cnt_r <= sat_next(tbl_rdata, head_taken_s);
        end
    end

    // Prediction valid follows a granted lookup by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predict_valid_r <= 1'b0;
        end else begin
            predict_valid_r <= lookup_grant_s;
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed testbench for bht_ctrl with a behavioural single-port table RAM.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_bht_ctrl;
    localparam int IDX_W  = 10;
    localparam int QDEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             lookup_valid;
    logic [31:0]      lookup_PC;
    logic             lookup_ready;
    logic             predict_valid;
    logic             predict_taken;
    logic             upd_valid;
    logic [31:0]      upd_PC;
    logic             upd_taken;
    logic             upd_ready;
    logic             init_req;
    logic             busy;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata = 2'b00;

    int errors = 0;
    int checks = 0;

    logic [1:0]       mem [0:(1<<IDX_W)-1];
    logic [IDX_W-1:0] wr_addr [0:7];
    logic [1:0]       wr_data [0:7];
    int               wr_n;

    always #5 clk = ~clk;

    bht_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_PC(lookup_PC), .lookup_ready(lookup_ready),
        .predict_valid(predict_valid), .predict_taken(predict_taken),
        .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .init_req(init_req), .busy(busy),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    // Table RAM model: write-or-read, read data one cycle later.
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata <= mem[tbl_addr];
        end
    end

    // Records table writes, sampling the current cycle first.
    task automatic collect_writes(input int ncyc);
        wr_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (tbl_en && tbl_we) begin
                if (wr_n < 8) begin
                    wr_addr[wr_n] = tbl_addr;
                    wr_data[wr_n] = tbl_wdata;
                end
                wr_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_not_busy(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk); #1;
            if (busy === 1'b0) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; lookup_valid = 1'b0; lookup_PC = 32'h0; upd_valid = 1'b0;
        upd_PC = 32'h0; upd_taken = 1'b0; init_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({predict_valid, predict_taken, lookup_ready, upd_ready, tbl_en, tbl_we, busy} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000001",
                     {predict_valid, predict_taken, lookup_ready, upd_ready, tbl_en, tbl_we, busy});
        end
    endtask

    task automatic test_init_sweep;
        int bad = 0;
        int first_bad = -1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            #1;
            if (!(tbl_en === 1'b1 && tbl_we === 1'b1 && tbl_addr === IDX_W'(i) && tbl_wdata === 2'b01 &&
                  lookup_ready === 1'b0 && upd_ready === 1'b0 && busy === 1'b1)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL init_sweep bad_cycles=%0d first=%0d exp 0", bad, first_bad);
        end
        #1;
        checks++;
        if ({lookup_ready, busy, upd_ready} !== 3'b101) begin
            errors++;
            $display("FAIL init_done ready/busy/upd_ready got=%b exp=101", {lookup_ready, busy, upd_ready});
        end
    endtask

    task automatic test_lookup;
        @(negedge clk);
        lookup_valid = 1'b1; lookup_PC = 32'h40;
        #1;
        checks++;
        if ({lookup_ready, tbl_en, tbl_we, tbl_addr} !== {3'b110, 10'h010}) begin
            errors++;
            $display("FAIL lookup_read got ready/en/we/addr=%b/%b/%b/%h exp 1/1/0/010",
                     lookup_ready, tbl_en, tbl_we, tbl_addr);
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        checks++;
        if ({predict_valid, predict_taken} !== 2'b10) begin
            errors++;
            $display("FAIL lookup_predict got=%b exp=10", {predict_valid, predict_taken});
        end
        @(negedge clk); #1;
        checks++;
        if (predict_valid !== 1'b0) begin
            errors++;
            $display("FAIL lookup_predict_drop got=%b exp=0", predict_valid);
        end
    endtask

    task automatic test_update_taken;
        @(negedge clk);
        upd_valid = 1'b1; upd_PC = 32'h100; upd_taken = 1'b1;
        #1;
        checks++;
        if (upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_push1 upd_ready got=%b exp=1", upd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({upd_ready, busy, tbl_en, tbl_we, tbl_addr} !== {4'b1110, 10'h040}) begin
            errors++;
            $display("FAIL upd_push2_read got rdy/busy/en/we/addr=%b/%b/%b/%b/%h exp 1/1/1/0/040",
                     upd_ready, busy, tbl_en, tbl_we, tbl_addr);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        collect_writes(20);
        checks++;
        if (wr_n !== 2 || wr_addr[0] !== 10'h040 || wr_data[0] !== 2'b10 ||
            wr_addr[1] !== 10'h040 || wr_data[1] !== 2'b11) begin
            errors++;
            $display("FAIL upd_writes got n=%0d %h:%b %h:%b exp n=2 040:10 040:11",
                     wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        @(negedge clk);
        lookup_valid = 1'b1; lookup_PC = 32'h100;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        checks++;
        if ({predict_valid, predict_taken} !== 2'b11) begin
            errors++;
            $display("FAIL upd_lookup_after got=%b exp=11", {predict_valid, predict_taken});
        end
    endtask

    task automatic test_saturation;
        logic [31:0] pc_tab [0:2];
        logic        tk_tab [0:2];
        pc_tab[0] = 32'h100; tk_tab[0] = 1'b1;   // 11 stays 11
        pc_tab[1] = 32'h200; tk_tab[1] = 1'b0;   // 01 -> 00
        pc_tab[2] = 32'h200; tk_tab[2] = 1'b0;   // 00 stays 00
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            upd_valid = 1'b1; upd_PC = pc_tab[k]; upd_taken = tk_tab[k];
            #1;
            checks++;
            if (upd_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_push%0d upd_ready got=%b exp=1", k, upd_ready);
            end
        end
        @(negedge clk);
        upd_valid = 1'b0;
        collect_writes(30);
        checks++;
        if (wr_n !== 3 || wr_addr[0] !== 10'h040 || wr_data[0] !== 2'b11 ||
            wr_addr[1] !== 10'h080 || wr_data[1] !== 2'b00 ||
            wr_addr[2] !== 10'h080 || wr_data[2] !== 2'b00) begin
            errors++;
            $display("FAIL sat_writes got n=%0d %h:%b %h:%b %h:%b exp n=3 040:11 080:00 080:00",
                     wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
        end
    endtask

    task automatic test_starvation;
        int n1 = 0;
        int n2 = 0;
        @(negedge clk);
        upd_valid = 1'b1; upd_PC = 32'h300; upd_taken = 1'b1;
        lookup_valid = 1'b1; lookup_PC = 32'h0;
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        while (lookup_ready === 1'b1 && n1 < 40) begin
            n1++;
            @(negedge clk); #1;
        end
        checks++;
        if (n1 !== 8 || tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== 10'h0C0) begin
            errors++;
            $display("FAIL starve_read denied=%0d en/we/addr=%b/%b/%h exp 8 1/0/0c0",
                     n1, tbl_en, tbl_we, tbl_addr);
        end
        @(negedge clk); #1;
        // CAP cycle grants the lookup, then 8 denied cycles in WR.
        while (lookup_ready === 1'b1 && n2 < 40) begin
            n2++;
            @(negedge clk); #1;
        end
        checks++;
        if (n2 !== 9 || tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_addr !== 10'h0C0 || tbl_wdata !== 2'b10) begin
            errors++;
            $display("FAIL starve_write gap=%0d en/we/addr/wdata=%b/%b/%h/%b exp 9 1/1/0c0/10",
                     n2, tbl_en, tbl_we, tbl_addr, tbl_wdata);
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        wait_not_busy(10);
    endtask

    task automatic test_queue_full;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lookup_valid = 1'b1; lookup_PC = 32'h0;
            upd_valid = 1'b1; upd_PC = 32'h404 + 32'(4 * k); upd_taken = 1'b1;
            #1;
            checks++;
            if (upd_ready !== 1'b1) begin
                errors++;
                $display("FAIL qfull_push%0d upd_ready got=%b exp=1", k, upd_ready);
            end
        end
        @(negedge clk);
        upd_PC = 32'h414;
        #1;
        checks++;
        if (upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL qfull_ready got=%b exp=0", upd_ready);
        end
        @(negedge clk);
        upd_valid = 1'b0; lookup_valid = 1'b0;
        collect_writes(40);
        checks++;
        if (wr_n !== 4) begin
            errors++;
            $display("FAIL qfull_nwrites got=%0d exp=4", wr_n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_addr[k] !== 10'h101 + IDX_W'(k) || wr_data[k] !== 2'b10) begin
                errors++;
                $display("FAIL qfull_write%0d got %h:%b exp %h:10", k, wr_addr[k], wr_data[k], 10'h101 + IDX_W'(k));
            end
        end
    endtask

    task automatic test_init_abort;
        int n = 0;
        int bad = 0;
        @(negedge clk);
        upd_valid = 1'b1; upd_PC = 32'h500; upd_taken = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        checks++;
        if ({tbl_en, tbl_we, tbl_addr} !== {2'b10, 10'h140}) begin
            errors++;
            $display("FAIL abort_read en/we/addr=%b/%b/%h exp 1/0/140", tbl_en, tbl_we, tbl_addr);
        end
        @(negedge clk);               // CAP: pulse init_req with a push that must be dropped
        init_req = 1'b1; upd_valid = 1'b1; upd_PC = 32'h600;
        @(negedge clk);
        init_req = 1'b0; upd_valid = 1'b0;
        #1;
        checks++;
        if ({tbl_en, tbl_we, tbl_addr, tbl_wdata, busy} !== {2'b11, 10'h000, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL abort_restart en/we/addr/wdata/busy=%b/%b/%h/%b/%b exp 1/1/000/01/1",
                     tbl_en, tbl_we, tbl_addr, tbl_wdata, busy);
        end
        repeat (5) @(negedge clk);
        init_req = 1'b1;              // restart again mid-sweep
        @(negedge clk);
        init_req = 1'b0;
        #1;
        while (busy === 1'b1 && n < 1100) begin
            if (tbl_en && tbl_we && tbl_wdata !== 2'b01) bad++;
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n !== 1024 || bad !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_sweep cycles=%0d badwr=%0d busy=%b exp 1024 0 0", n, bad, busy);
        end
        @(negedge clk);
        lookup_valid = 1'b1; lookup_PC = 32'h500;
        @(negedge clk);
        lookup_PC = 32'h600;
        #1;
        checks++;
        if ({predict_valid, predict_taken} !== 2'b10) begin
            errors++;
            $display("FAIL abort_lookup500 got=%b exp=10", {predict_valid, predict_taken});
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        checks++;
        if ({predict_valid, predict_taken} !== 2'b10) begin
            errors++;
            $display("FAIL abort_lookup600 got=%b exp=10", {predict_valid, predict_taken});
        end
    endtask

    task automatic test_reset_mid_rmw;
        @(negedge clk);
        upd_valid = 1'b1; upd_PC = 32'h700; upd_taken = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);               // CAP
        rst = 1'b0;
        #1;
        checks++;
        if ({tbl_en, tbl_we, lookup_ready, upd_ready, predict_valid, busy} !== 6'b000001) begin
            errors++;
            $display("FAIL rmw_reset outputs got=%b exp=000001",
                     {tbl_en, tbl_we, lookup_ready, upd_ready, predict_valid, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({tbl_en, tbl_we, tbl_addr} !== {2'b11, 10'h000}) begin
            errors++;
            $display("FAIL rmw_restart en/we/addr=%b/%b/%h exp 1/1/000", tbl_en, tbl_we, tbl_addr);
        end
        wait_not_busy(1100);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rmw_sweep_done busy got=%b exp=0", busy);
        end
        @(negedge clk);
        lookup_valid = 1'b1; lookup_PC = 32'h700;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        checks++;
        if ({predict_valid, predict_taken} !== 2'b10) begin
            errors++;
            $display("FAIL rmw_lookup got=%b exp=10", {predict_valid, predict_taken});
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << IDX_W); i++) mem[i] = 2'b00;
        test_reset();
        test_init_sweep();
        test_lookup();
        test_update_taken();
        test_saturation();
        test_starvation();
        test_queue_full();
        test_init_abort();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bht_ctrl.md
BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 10, table index width (2^IDX_W two-bit counters, index = PC[IDX_W+1:2]).
REQ-002 SHALL have parameter QDEPTH, default 4, update-queue depth (power of two).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 lookup_valid  in  1  fetch requests a prediction.
REQ-007 lookup_PC  in  32  fetch PC.
REQ-008 lookup_ready  out  1  lookup granted this cycle when high with lookup_valid.
REQ-009 predict_valid  out  1  predict_taken valid this cycle.
REQ-010 predict_taken  out  1  predicted direction.
REQ-011 upd_valid  in  1  resolved branch presented.
REQ-012 upd_PC  in  32  resolved branch PC.
REQ-013 upd_taken  in  1  resolved direction.
REQ-014 upd_ready  out  1  queue accepts update; push on upd_valid&&upd_ready.
REQ-015 init_req  in  1  one-cycle pulse: flush and re-initialize table.
REQ-016 busy  out  1  init sweep active, queue non-empty, or RMW in flight.
REQ-017 tbl_en, tbl_we  out  1 each  single-port table strobe and write enable.
REQ-018 tbl_addr  out  IDX_W  table index; tbl_wdata  out  2  write counter.
REQ-019 tbl_rdata  in  2  read data, valid the cycle after a read (tbl_en&&!tbl_we).

Function
REQ-020 Control FSM SHALL have states INIT, IDLE, CAP, WR.
REQ-021 INIT: one write per cycle, addr 0..2^IDX_W-1, wdata 2'b01; after last address -> IDLE; lookup_ready=0, upd_ready=0 throughout.
REQ-022 upd_ready SHALL equal (queue not full) && state!=INIT; no same-cycle push-when-full pass-through.
REQ-023 Queue entries SHALL hold {upd_PC[IDX_W+1:2], upd_taken}, FIFO order.
REQ-024 Port owner per cycle outside INIT: forced update if starve_cnt==8 and update op pending; else lookup if lookup_valid; else update op.
REQ-025 Update op pending = (IDLE && queue non-empty) or WR.
REQ-026 lookup_ready SHALL be 1 outside INIT except in forced-update cycles.
REQ-027 Granted lookup: tbl_en=1, tbl_we=0, tbl_addr=lookup_PC[IDX_W+1:2]; next cycle predict_valid=1, predict_taken=tbl_rdata[1]; otherwise predict_valid=0, predict_taken=0.
REQ-028 IDLE with granted update: read head index -> CAP.
REQ-029 CAP: port free for lookup; register saturated next counter from tbl_rdata and head taken -> WR.
REQ-030 Saturation: taken: 00->01, 01->10, 10->11, 11->11; not-taken: 11->10, 10->01, 01->00, 00->00.
REQ-031 WR with grant: write registered counter to head index, pop queue -> IDLE.
REQ-032 starve_cnt (4 bit) SHALL increment each cycle an update op is pending and not granted, clear when granted.
REQ-033 Lookups SHALL read table contents only; queued updates are not forwarded.
REQ-034 Consecutive updates to one index SHALL each observe the previous write (RMW serialized).
REQ-035 init_req outside reset SHALL flush queue, abort RMW (no write), clear starve_cnt, restart INIT at address 0, including during INIT.
REQ-036 Push SHALL be ignored in the init_req cycle.

Reset
REQ-037 On rst low: state=INIT, sweep address 0, queue empty, starve_cnt=0, predict_valid=0, predict_taken=0, lookup_ready=0, upd_ready=0, tbl_en=0, tbl_we=0, busy=1.
REQ-038 Reset mid-RMW SHALL discard the RMW; sweep restarts after release.

Verification
REQ-039 Release reset, IDX_W=10 -> 1024 cycles tbl_we=1, addr 0..1023, wdata 01; then lookup_ready=1, busy=0.
REQ-040 After init, lookup PC 0x40 -> tbl_addr 0x010, next cycle predict_valid=1, predict_taken=0.
REQ-041 Two taken updates PC 0x100, no lookups -> writes 2'b10 then 2'b11 at addr 0x040; later lookup predict_taken=1.
REQ-042 lookup_valid held high, one update queued -> after 8 denied cycles lookup_ready=0 once, read issues; write forced 8 cycles later.
REQ-043 lookup_valid held high, 4 pushes -> upd_ready=0; 5th upd_valid not accepted; no loss after lookups stop.
REQ-044 init_req in CAP -> no write for that entry, queue empty, next cycle tbl_addr=0 tbl_we=1, busy=1.
